// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and framing constants for the instruction memory loader
package imem_loader_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_packer.sv
// rtl/imem_loader_packer.sv - little-endian byte to 32-bit word assembler
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word_out
);

    logic [1:0]  byte_idx;
    logic [23:0] shift;

    // Bytes enter at the top and move down, so byte 0 ends in bits [7:0].
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_idx   <= '0;
            shift      <= '0;
            word_valid <= 1'b0;
            word_out   <= '0;
        end else if (clear) begin
            byte_idx   <= '0;
            shift      <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (byte_valid) begin
                if (byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                    word_out   <= {byte_in, shift};
                    word_valid <= 1'b1;
                    byte_idx   <= '0;
                    shift      <= '0;
                end else begin
                    shift    <= {byte_in, shift[23:8]};
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader streaming a length-prefixed program into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    logic [2:0]            state, next_state;
    logic [7:0]            count_lo;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH+1:0] byte_cnt;
    logic [15:0]           hdr_count;
    logic                  hs, data_hs, start_ok, last_accept, too_big, in_ready_next;
    logic                  word_valid;
    logic [31:0]           word_out;

    assign hdr_count   = {in_data, count_lo};
    assign hs          = in_valid && in_ready;
    assign data_hs     = hs && (state == S_DATA);
    assign start_ok    = start && (state == S_IDLE || state == S_RUN || state == S_ERROR);
    assign too_big     = {1'b0, hdr_count} > (17'd1 << ADDR_WIDTH);
    // Final byte of the final word: stop accepting before the write lands.
    assign last_accept = data_hs && (byte_cnt == {last_idx, 2'b11});

    byte_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (start_ok),
        .byte_valid (data_hs),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word_out   (word_out)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_HDR0;
            S_HDR0:  if (hs) next_state = S_HDR1;
            S_HDR1: begin
                if (hs) begin
                    if (hdr_count == 16'd0) next_state = S_DONE;
                    else if (too_big)       next_state = S_ERROR;
                    else                    next_state = S_DATA;
                end
            end
            S_DATA:  if (word_valid && wr_idx == last_idx) next_state = S_DONE;
            S_DONE:  next_state = S_RUN;
            S_RUN:   if (start) next_state = S_HDR0;
            S_ERROR: if (start) next_state = S_HDR0;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_next = 1'b0;
        case (next_state)
            S_HDR0, S_HDR1: in_ready_next = 1'b1;
            S_DATA:         in_ready_next = (state == S_DATA) ? (in_ready && !last_accept) : 1'b1;
            default:        in_ready_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            count_lo   <= '0;
            last_idx   <= '0;
            wr_idx     <= '0;
            byte_cnt   <= '0;
        end else begin
            state     <= next_state;
            in_ready  <= in_ready_next;
            imem_we   <= 1'b0;
            done      <= (state == S_DONE);
            cpu_reset <= !(state == S_RUN && !start);

            if (state == S_HDR0 && hs) count_lo <= in_data;
            if (state == S_HDR1 && hs) last_idx <= ADDR_WIDTH'(hdr_count - 16'd1);

            if (start_ok) begin
                byte_cnt <= '0;
                wr_idx   <= '0;
            end else if (data_hs) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            if (state == S_DATA && word_valid) begin
                imem_we    <= 1'b1;
                imem_addr  <= wr_idx;
                imem_wdata <= WORD_WIDTH'(word_out);
                wr_idx     <= wr_idx + 1'b1;
            end

            if (state == S_HDR1 && hs && too_big) error <= 1'b1;
            else if (start_ok)                    error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int AW = 6;

    logic          clock = 1'b0;
    logic          reset, start, in_valid, in_ready;
    logic [7:0]    in_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset, done, error;

    imem_loader #(.ADDR_WIDTH(AW), .WORD_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [31:0] wbuf [0:63];
    int          nwr = 0, done_cnt = 0, done_cyc = 0, cr_fall = 0, first_we = -1;
    int          last_addr = 0, start_edge = 0, last_acc = 0;
    logic        prev_cr = 1'b1;

    always @(negedge clock) begin
        if (imem_we) begin
            nwr++;
            last_addr = 32'(imem_addr);
            if (first_we < 0) first_we = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", 32'(imem_addr), 32'(e.a));
                check("we_data", imem_wdata, e.d);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_cr && !cpu_reset) cr_fall = cyc;
        prev_cr = cpu_reset;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        start_edge = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            step();
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
        last_acc = cyc + 1;
        step();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic run_load(input int n, input int gap_at);
        int d0, w0, t;
        logic [15:0] hdr;
        hdr      = 16'(n);
        d0       = done_cnt;
        w0       = nwr;
        first_we = -1;
        pulse_start();
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart_ready", 32'(in_ready), 32'd1);
        send_byte(hdr[7:0]);
        send_byte(hdr[15:8]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a: AW'(i), d: wbuf[i]});
            for (int k = 0; k < 4; k++) begin
                send_byte(wbuf[i][8*k +: 8]);
                if (i * 4 + k == gap_at) begin
                    in_valid = 1'b0;
                    repeat (3) step();
                end
            end
        end
        idle_in();
        t = 0;
        while (done_cnt == d0 && t < 40) begin
            step();
            t++;
        end
        check("done_seen", 32'(done_cnt - d0), 32'd1);
        check("done_lat", 32'(done_cyc - last_acc), (n == 0) ? 32'd1 : 32'd2);
        step();
        check("done_pulse", 32'(done), 32'd0);
        check("cpu_reset_low", 32'(cpu_reset), 32'd0);
        check("cr_lat", 32'(cr_fall - done_cyc), 32'd1);
        check("n_writes", 32'(nwr - w0), 32'(n));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("error_clear", 32'(error), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int w0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) step();
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        reset = 1'b0;
        step();

        // two words at full rate
        wbuf[0] = 32'hF840_0202;
        wbuf[1] = 32'hF840_0602;
        run_load(2, -1);
        check("first_we_lat", 32'(first_we - start_edge), 32'd7);

        // same stream with a 3-cycle stall mid-word
        run_load(2, 2);
        check("gap_we_lat", 32'(first_we - start_edge), 32'd10);

        // empty program
        run_load(0, -1);

        // oversize header
        w0 = nwr;
        pulse_start();
        send_byte(8'h41);
        send_byte(8'h00);
        idle_in();
        repeat (3) step();
        check("err_flag", 32'(error), 32'd1);
        check("err_ready", 32'(in_ready), 32'd0);
        check("err_cpu_reset", 32'(cpu_reset), 32'd1);
        check("err_no_we", 32'(nwr - w0), 32'd0);
        run_load(2, -1);

        // full capacity, last address all-ones
        for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
        run_load(64, -1);
        check("cap_last_addr", 32'(last_addr), 32'd63);

        // reset mid-load discards the partial word
        w0 = nwr;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
        check("mid_ready", 32'(in_ready), 32'd0);
        check("mid_done", 32'(done), 32'd0);
        check("mid_error", 32'(error), 32'd0);
        check("mid_addr", 32'(imem_addr), 32'd0);
        check("mid_wdata", imem_wdata, 32'd0);
        repeat (3) step();
        check("mid_no_we", 32'(nwr - w0), 32'd0);
        wbuf[0] = 32'h8B03_0050;
        run_load(1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the instruction fetch stage of PipelinedARMv8.
- Accepts a byte stream (length header followed by little-endian 32-bit instruction words) over a valid/ready handshake.
- Writes each assembled word into instruction memory through a dedicated write port.
- Holds the core in reset (cpu_reset) until a complete program has been written, replacing $readmemh preloading for on-silicon and bench use.

Parameters:
- ADDR_WIDTH, 6, instruction memory word-address width; capacity = 2**ADDR_WIDTH words.
- WORD_WIDTH, 32, instruction width; fixed at 32 (4 bytes per word).

Ports:
- clock  in  1  rising-edge clock shared with PipelinedARMv8.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a (re)load; honoured only in IDLE, RUN or ERROR.
- in_valid  in  1  byte stream valid.
- in_ready  out  1  loader can accept a byte this cycle.
- in_data  in  8  byte stream payload.
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  WORD_WIDTH  assembled instruction word.
- cpu_reset  out  1  reset to the core; high while not in RUN.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  sticky flag: header word count exceeds capacity.

Behaviour:
- Handshake: a byte transfers on a rising edge where in_valid && in_ready. in_ready is a registered output and is high only in HDR0, HDR1 and DATA. in_data is ignored otherwise.
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, error=0. Internal word counter, byte index and shift register are all 0.
- IDLE: cpu_reset=1. On start go to HDR0.
- HDR0: accept byte -> count[7:0]; go to HDR1.
- HDR1: accept byte -> count[15:8]. Next state:
  - DONE if count==0;
  - ERROR if count > 2**ADDR_WIDTH;
  - DATA otherwise.
- DATA (little-endian assembly):
  - Byte k (k=0..3) of a word goes to bits [8k+7:8k].
  - On the handshake of byte 3, on the next edge: imem_we=1 for exactly one cycle, imem_addr=word index (starting at 0), imem_wdata=assembled word.
  - in_ready stays high across word boundaries, so back-to-back bytes sustain 1 byte/cycle.
  - After writing word count-1, go to DONE. No further bytes are accepted and in_ready drops the same edge.
- DONE: one cycle. done=1, and cpu_reset is deasserted on the following edge. Go to RUN.
- RUN: cpu_reset=0, in_ready=0. On start: cpu_reset=1 on the next edge and go to HDR0. Memory contents are overwritten word by word; stale words beyond the new count remain.
- ERROR: error=1 (sticky), cpu_reset=1, in_ready=0. On start: clear error and go to HDR0.
- Boundary conditions:
  - start in HDR0/HDR1/DATA/DONE is ignored.
  - count == 2**ADDR_WIDTH is legal; the final imem_addr is all-ones and there is no wrap.
  - in_valid gaps mid-word hold the byte index and shift register unchanged.
  - reset mid-load returns all outputs to reset values. The partially assembled word is discarded; words already written stay in memory.
- Latency: header to first write = 4 accepted bytes + 1 cycle. Last byte accepted to done = 2 cycles. done to cpu_reset low = 1 cycle.

Decomposition:
- Package imem_loader_pkg: state enum (IDLE, HDR0, HDR1, DATA, DONE, RUN, ERROR); BYTES_PER_WORD=4; HDR_BYTES=2.
- Sub-module byte_word_packer: byte index counter plus shift register. Ports: clock, reset, clear, byte_valid, byte_in[7:0], word_valid (1-cycle), word_out[31:0].
- The top level keeps the FSM, word counter, address and header logic.

Test Plan:
- Reset held 3 cycles -> cpu_reset=1, in_ready=0, imem_we=0, done=0, error=0. Send start -> in_ready=1 next cycle.
- start, bytes 02 00 | 02 02 40 F8 | 02 06 40 F8 at 1 byte/cycle -> imem_we pulses: addr0=0xF8400202, addr1=0xF8400602. done 2 cycles after the last byte; cpu_reset=0 one cycle later.
- Same stream with in_valid low for 3 cycles after byte 2 of word 0 -> identical memory writes. Write timing is shifted by exactly 3 cycles.
- Header 41 00 with ADDR_WIDTH=6 (65 > 64) -> error=1, in_ready=0, cpu_reset=1, no imem_we. start then a valid stream -> error clears and the load succeeds.
- Header 00 00 -> no writes; done pulse the cycle after byte 2 is accepted; cpu_reset deasserts the cycle after that.
- reset asserted after 2 of 4 data bytes -> outputs return to reset values, no imem_we. start and a full reload of 1 word (0x8B030050) -> addr0=0x8B030050.
